// File: rtl/video_scanout_if.sv
// Read-side link between video_scanout and the asyncfifo that feeds it.
// The FIFO is first-word fall-through: fifo_read_data is valid while
// fifo_can_read is high, and a pop happens on the clock edge where
// fifo_read is high.
interface video_scanout_if;
  logic        fifo_can_read;
  logic [15:0] fifo_read_data;
  logic        fifo_read;

  // Scanout side: consumes words and issues pops
  modport master (
    input  fifo_can_read,
    input  fifo_read_data,
    output fifo_read
  );

  // FIFO side: presents words and receives pops
  modport slave (
    output fifo_can_read,
    output fifo_read_data,
    input  fifo_read
  );
endinterface

// File: rtl/video_scanout.sv
// Pixel-clock raster generator and FIFO consumer.
// Walks an h/v counter pair over the full raster, pops one RGB565 word per
// visible pixel and drives registered sync/active/pixel outputs one cycle
// behind the counter position. A visible pixel with no word available is
// shown as black and latches a sticky underflow flag.
module video_scanout #(
  parameter int H_ACTIVE         = 640,
  parameter int H_FRONT          = 16,
  parameter int H_SYNC           = 96,
  parameter int H_BACK           = 48,
  parameter int V_ACTIVE         = 480,
  parameter int V_FRONT          = 10,
  parameter int V_SYNC           = 2,
  parameter int V_BACK           = 33,
  parameter bit SYNC_ACTIVE_HIGH = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  underflow_clear,
  video_scanout_if.master       fifo,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  active,
  output logic [15:0]           pixel,
  output logic                  frame_start,
  output logic                  underflow
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  // Region boundaries, sized to the 12-bit counters
  localparam logic [11:0] H_VIS_END  = 12'(H_ACTIVE);
  localparam logic [11:0] HS_START   = 12'(H_ACTIVE + H_FRONT);
  localparam logic [11:0] HS_END     = 12'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_VIS_END  = 12'(V_ACTIVE);
  localparam logic [11:0] VS_START   = 12'(V_ACTIVE + V_FRONT);
  localparam logic [11:0] VS_END     = 12'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);

  // Level a sync line rests at when no pulse is being driven
  localparam logic SYNC_IDLE = SYNC_ACTIVE_HIGH ? 1'b0 : 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RUN
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [11:0] h;
  logic [11:0] v;

  logic running;
  logic h_last;
  logic v_last;
  logic frame_end;
  logic vis;
  logic hs_raw;
  logic vs_raw;

  assign running   = (state == ST_RUN);
  assign h_last    = (h == H_LAST);
  assign v_last    = (v == V_LAST);
  assign frame_end = running && h_last && v_last;
  assign vis       = (h < H_VIS_END) && (v < V_VIS_END);
  assign hs_raw    = (h >= HS_START) && (h < HS_END);
  assign vs_raw    = (v >= VS_START) && (v < VS_END);

  // Pop only for a visible pixel that actually has a word behind it
  assign fifo.fifo_read = running && vis && fifo.fifo_can_read;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: enable only matters in IDLE/WAIT and at the end of a frame
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (enable) begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!enable) begin
          state_next = ST_IDLE;
        end else if (fifo.fifo_can_read) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (frame_end && !enable) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Raster counters; held at the origin whenever not scanning
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h <= '0;
      v <= '0;
    end else if (!running) begin
      h <= '0;
      v <= '0;
    end else if (h_last) begin
      h <= '0;
      v <= v_last ? 12'd0 : v + 12'd1;
    end else begin
      h <= h + 12'd1;
    end
  end

  // Registered video outputs, one cycle behind the counter position
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync       <= SYNC_IDLE;
      vsync       <= SYNC_IDLE;
      active      <= 1'b0;
      pixel       <= '0;
      frame_start <= 1'b0;
    end else if (running) begin
      hsync       <= hs_raw ^ SYNC_IDLE;
      vsync       <= vs_raw ^ SYNC_IDLE;
      active      <= vis;
      pixel       <= (vis && fifo.fifo_can_read) ? fifo.fifo_read_data : 16'h0000;
      frame_start <= (h == 12'd0) && (v == 12'd0);
    end else begin
      hsync       <= SYNC_IDLE;
      vsync       <= SYNC_IDLE;
      active      <= 1'b0;
      pixel       <= '0;
      frame_start <= 1'b0;
    end
  end

  // Sticky underflow flag; a fresh underflow beats a simultaneous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      underflow <= 1'b0;
    end else if (running && vis && !fifo.fifo_can_read) begin
      underflow <= 1'b1;
    end else if (underflow_clear) begin
      underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_video_scanout.sv
// Bench for video_scanout on a tiny 8x6 raster with active-high syncs.
// A queue stands in for the FWFT asyncfifo; expected outputs come from the
// raster position (cycle index within a frame) and a queue of the words
// that were pushed, consumed one per visible pixel.
module tb_video_scanout;

  localparam int HA = 4;
  localparam int HF = 1;
  localparam int HS = 2;
  localparam int HB = 1;
  localparam int VA = 3;
  localparam int VF = 1;
  localparam int VS = 1;
  localparam int VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        underflow_clear;
  logic        hsync;
  logic        vsync;
  logic        active;
  logic [15:0] pixel;
  logic        frame_start;
  logic        underflow;

  video_scanout_if fif ();

  video_scanout #(
    .H_ACTIVE        (HA),
    .H_FRONT         (HF),
    .H_SYNC          (HS),
    .H_BACK          (HB),
    .V_ACTIVE        (VA),
    .V_FRONT         (VF),
    .V_SYNC          (VS),
    .V_BACK          (VB),
    .SYNC_ACTIVE_HIGH(1'b1)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .underflow_clear(underflow_clear),
    .fifo           (fif),
    .hsync          (hsync),
    .vsync          (vsync),
    .active         (active),
    .pixel          (pixel),
    .frame_start    (frame_start),
    .underflow      (underflow)
  );

  always #5 clk = ~clk;

  logic [15:0] fq[$];
  logic [15:0] mq[$];
  int          total_checks = 0;
  int          passed_checks = 0;
  int          pops_seen;
  int          act_seen;
  int          clr_a;
  int          clr_b;
  int          drop_at;
  logic        rd_sampled;
  logic        exp_uf;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_checks++;
    assert (obs === exp) passed_checks++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic refresh_fifo();
    fif.fifo_can_read  = (fq.size() != 0);
    fif.fifo_read_data = (fq.size() != 0) ? fq[0] : 16'h0000;
  endtask

  task automatic push(input logic [15:0] w);
    fq.push_back(w);
    mq.push_back(w);
    refresh_fifo();
  endtask

  // One clock: sample the pop request mid-cycle, then let the FIFO react
  task automatic tick();
    @(negedge clk);
    rd_sampled = fif.fifo_read;
    @(posedge clk);
    #1;
    if (rd_sampled && fq.size() != 0) begin
      void'(fq.pop_front());
      pops_seen++;
    end
    refresh_fifo();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".hsync"}, {15'd0, hsync}, 16'd0);
    check({tag, ".vsync"}, {15'd0, vsync}, 16'd0);
    check({tag, ".active"}, {15'd0, active}, 16'd0);
    check({tag, ".pixel"}, pixel, 16'h0000);
    check({tag, ".frame_start"}, {15'd0, frame_start}, 16'd0);
    check({tag, ".fifo_read"}, {15'd0, fif.fifo_read}, 16'd0);
  endtask

  // Walk raster positions 0..count-1 of a frame that has just started
  task automatic run_positions(input int count);
    for (int n = 0; n < count; n++) begin
      int          h;
      int          v;
      logic        vis;
      logic        got_word;
      logic        set_uf;
      logic [15:0] exp_pix;
      h = n % HT;
      v = n / HT;
      underflow_clear = (n == clr_a) || (n == clr_b);
      if (n == drop_at) enable = 1'b0;
      vis      = (h < HA) && (v < VA);
      got_word = vis && (mq.size() != 0);
      exp_pix  = got_word ? mq.pop_front() : 16'h0000;
      set_uf   = vis && !got_word;
      tick();
      if (active) act_seen++;
      exp_uf = set_uf ? 1'b1 : (underflow_clear ? 1'b0 : exp_uf);
      check("fifo_read", {15'd0, rd_sampled}, {15'd0, got_word});
      check("active", {15'd0, active}, {15'd0, vis});
      check("pixel", pixel, exp_pix);
      check("hsync", {15'd0, hsync}, {15'd0, (h >= HA + HF) && (h < HA + HF + HS)});
      check("vsync", {15'd0, vsync}, {15'd0, (v >= VA + VF) && (v < VA + VF + VS)});
      check("frame_start", {15'd0, frame_start}, {15'd0, n == 0});
      check("underflow", {15'd0, underflow}, {15'd0, exp_uf});
    end
    underflow_clear = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    enable          = 1'b0;
    underflow_clear = 1'b0;
    clr_a           = -1;
    clr_b           = -1;
    drop_at         = -1;
    exp_uf          = 1'b0;
    pops_seen       = 0;
    act_seen        = 0;
    refresh_fifo();

    // Reset state
    #2;
    check_idle_outputs("reset");
    check("reset.underflow", {15'd0, underflow}, 16'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Prefill guard: enabled but FIFO empty keeps the raster parked
    enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("prefill.fifo_read", {15'd0, rd_sampled}, 16'd0);
      check("prefill.active", {15'd0, active}, 16'd0);
    end

    // First word arrives; the next edge enters RUN
    push(16'h0001);
    tick();
    check("entry.frame_start", {15'd0, frame_start}, 16'd0);
    check("entry.active", {15'd0, active}, 16'd0);
    for (int i = 2; i <= 12; i++) push(16'(i));
    for (int i = 0; i < 12; i++) push(16'($urandom));

    // Frame 1: sequential data, enable held so frame 2 follows directly
    pops_seen = 0;
    act_seen  = 0;
    run_positions(FRAME);
    check("frame1.pops", 16'(pops_seen), 16'd12);

    // Frame 2: random data, enable dropped mid-frame
    pops_seen = 0;
    act_seen  = 0;
    drop_at   = 10;
    run_positions(FRAME);
    drop_at   = -1;
    check("frame2.active_cycles", 16'(act_seen), 16'd12);
    check("frame2.pops", 16'(pops_seen), 16'd12);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_idle_outputs("after_drop");
    end

    // Underflow: only two words queued for a whole frame
    push(16'h00AA);
    push(16'h00BB);
    enable = 1'b1;
    tick();
    tick();
    check("uf_entry.frame_start", {15'd0, frame_start}, 16'd0);
    drop_at = 5;
    clr_a   = 12;
    clr_b   = 16;
    run_positions(FRAME);
    drop_at = -1;
    clr_a   = -1;
    clr_b   = -1;
    tick();
    check_idle_outputs("after_uf");
    check("uf_sticky", {15'd0, underflow}, 16'd1);
    underflow_clear = 1'b1;
    tick();
    underflow_clear = 1'b0;
    exp_uf = 1'b0;
    check("uf_clear_idle", {15'd0, underflow}, 16'd0);

    // Reset in the middle of a visible line
    for (int i = 0; i < 20; i++) push(16'($urandom));
    enable = 1'b1;
    tick();
    tick();
    run_positions(3);
    check("pre_reset.active", {15'd0, active}, 16'd1);
    reset = 1'b1;
    #1;
    check_idle_outputs("async_reset");
    check("async_reset.underflow", {15'd0, underflow}, 16'd0);
    exp_uf = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    check("rst_wait.active", {15'd0, active}, 16'd0);
    tick();
    check("rst_entry.frame_start", {15'd0, frame_start}, 16'd0);
    pops_seen = 0;
    drop_at   = 0;
    run_positions(FRAME);
    drop_at   = -1;
    check("rst_frame.pops", 16'(pops_seen), 16'd12);
    tick();
    check_idle_outputs("final_idle");

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
